// File: rtl/br_lite_local_ni_pkg.sv
// br_lite_local_ni_pkg: flit, service, id and NI TX state types for the BrLite local network interface
package br_lite_local_ni_pkg;
  localparam int BR_ID_W = 4;
  localparam int BR_PAYLOAD_W = 8;
  typedef enum logic [1:0] {
    BR_SVC_ALL   = 2'd0,
    BR_SVC_TGT   = 2'd1,
    BR_SVC_CLEAR = 2'd2
  } br_svc_t;
  typedef logic [BR_ID_W-1:0] br_id_t;
  typedef logic [BR_PAYLOAD_W-1:0] br_payload_t;
  typedef struct packed {
    logic [15:0] source;
    logic [15:0] target;
    br_svc_t     service;
    br_id_t      id;
    br_payload_t payload;
  } br_data_t;
  typedef enum logic [1:0] {TX_IDLE, TX_WAIT, TX_REQ, TX_RELEASE} br_ni_tx_state_t;
endpackage

// File: rtl/br_lite_ni_fifo.sv
// br_lite_ni_fifo: first-word-fall-through FIFO with occupancy count for the NI RX path
module br_lite_ni_fifo import br_lite_local_ni_pkg::*; #(
  parameter int DEPTH = 4,
  parameter type T = br_data_t,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  T            din,
  input  logic        pop,
  output T            dout,
  output logic        valid,
  output logic        full,
  output logic [AW:0] count
);
  T mem [DEPTH];
  logic [AW-1:0] wr, rd;
  assign valid = count != '0;
  assign full = count == (AW+1)'(DEPTH);
  // empty head reads as zero so the PE-facing data bus is clean out of reset
  assign dout = valid ? mem[rd] : '0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr <= '0;
      rd <= '0;
      count <= '0;
    end else begin
      if (push) wr <= wr + 1'b1;
      if (pop) rd <= rd + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr] <= din;
  end
endmodule

// File: rtl/br_lite_local_ni.sv
// br_lite_local_ni: PE-side NI on the BrLite LOCAL port (TX req/ack injector, RX FIFO); BR_LITE_NI_CLEAR_FWD_EN forwards CLEAR flits to the PE
module br_lite_local_ni import br_lite_local_ni_pkg::*; #(
  parameter logic [15:0] ADDRESS = 16'h0000,
  parameter int RX_DEPTH = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      tx_valid_i,
  output logic                      tx_ready_o,
  input  logic                      tx_tgt_i,
  input  logic [15:0]               tx_target_i,
  input  br_payload_t               tx_payload_i,
  output br_data_t                  br_flit_o,
  output logic                      br_req_o,
  input  logic                      br_ack_i,
  input  logic                      local_busy_i,
  input  br_data_t                  br_flit_i,
  input  logic                      br_req_i,
  output logic                      br_ack_o,
  output logic                      rx_valid_o,
  input  logic                      rx_ready_i,
  output br_data_t                  rx_data_o,
  output logic [$clog2(RX_DEPTH):0] rx_count_o
);
  br_ni_tx_state_t state, state_next;
  br_data_t hold;
  br_id_t id_cnt;
  logic live, accept, clear_drop, rx_take, rx_push, rx_full;
  // live keeps tx_ready low while reset is held and rises on the first clock after release
  assign tx_ready_o = live && state == TX_IDLE;
  assign accept = tx_valid_i && tx_ready_o;
  assign br_req_o = state == TX_REQ;
  assign br_flit_o = hold;
  always_comb begin
    state_next = state;
    case (state)
      TX_IDLE:    state_next = accept ? TX_WAIT : TX_IDLE;
      TX_WAIT:    state_next = local_busy_i ? TX_WAIT : TX_REQ;
      TX_REQ:     state_next = br_ack_i ? TX_RELEASE : TX_REQ;
      TX_RELEASE: state_next = br_ack_i ? TX_RELEASE : TX_IDLE;
      default:    state_next = TX_IDLE;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= TX_IDLE;
      hold <= '0;
      id_cnt <= '0;
      live <= 1'b0;
    end else begin
      live <= 1'b1;
      state <= state_next;
      if (accept) begin
        hold.source <= ADDRESS;
        hold.target <= tx_tgt_i ? tx_target_i : 16'h0000;
        hold.service <= tx_tgt_i ? BR_SVC_TGT : BR_SVC_ALL;
        hold.id <= id_cnt;
        hold.payload <= tx_payload_i;
        id_cnt <= id_cnt + 1'b1;
      end
    end
  end
`ifdef BR_LITE_NI_CLEAR_FWD_EN
  assign clear_drop = 1'b0;
`else
  assign clear_drop = br_flit_i.service == BR_SVC_CLEAR;
`endif
  // dropped CLEAR flits bypass the full check since they never occupy a slot
  assign rx_take = br_req_i && !br_ack_o && (clear_drop || !rx_full);
  assign rx_push = rx_take && !clear_drop;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) br_ack_o <= 1'b0;
    else br_ack_o <= br_req_i && (br_ack_o || rx_take);
  end
  br_lite_ni_fifo #(.DEPTH(RX_DEPTH), .T(br_data_t)) u_fifo (
    .clk(clk_i),
    .rst(rst_i),
    .push(rx_push),
    .din(br_flit_i),
    .pop(rx_valid_o && rx_ready_i),
    .dout(rx_data_o),
    .valid(rx_valid_o),
    .full(rx_full),
    .count(rx_count_o)
  );
endmodule

// File: tb/tb_br_lite_local_ni.sv
// tb_br_lite_local_ni: randomized self-checking bench for br_lite_local_ni against a queue/counter reference model
module tb_br_lite_local_ni;
  import br_lite_local_ni_pkg::*;
`ifdef BR_LITE_NI_CLEAR_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  localparam int DEPTH = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic tx_valid = 0, tx_ready, tx_tgt = 0, br_req_o, br_ack_i = 0, local_busy = 0;
  logic br_req_i = 0, br_ack_o, rx_valid, rx_ready = 0;
  logic [15:0] tx_target = 0;
  br_payload_t tx_payload = 0;
  br_data_t br_flit_o, br_flit_i = '0, rx_data;
  logic [2:0] rx_count;
  int n_cmp = 0, n_err = 0;
  int sent = 0;
  br_data_t rxq[$];

  br_lite_local_ni #(.ADDRESS(16'h0101), .RX_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready),
    .tx_tgt_i(tx_tgt), .tx_target_i(tx_target), .tx_payload_i(tx_payload),
    .br_flit_o(br_flit_o), .br_req_o(br_req_o), .br_ack_i(br_ack_i),
    .local_busy_i(local_busy), .br_flit_i(br_flit_i), .br_req_i(br_req_i),
    .br_ack_o(br_ack_o), .rx_valid_o(rx_valid), .rx_ready_i(rx_ready),
    .rx_data_o(rx_data), .rx_count_o(rx_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic br_data_t rand_flit();
    br_data_t f;
    f.source = 16'($urandom);
    f.target = 16'($urandom);
    f.service = br_svc_t'($urandom_range(0, 2));
    f.id = br_id_t'($urandom);
    f.payload = br_payload_t'($urandom);
    return f;
  endfunction

  task automatic test_reset();
    #2;
    n_cmp++; if ({br_req_o, br_ack_o, rx_valid, tx_ready} !== 4'b0) begin n_err++; $display("FAIL reset_ctrl got %b want 0000", {br_req_o, br_ack_o, rx_valid, tx_ready}); end
    n_cmp++; if (br_flit_o !== '0 || rx_data !== '0 || rx_count !== 3'd0) begin n_err++; $display("FAIL reset_data got flit=%h data=%h cnt=%0d want 0", br_flit_o, rx_data, rx_count); end
    repeat (2) step();
    rst = 1'b0;
    step();
    n_cmp++; if (tx_ready !== 1'b1) begin n_err++; $display("FAIL reset_release_ready got %b want 1", tx_ready); end
  endtask

  // one PE send through the full req/ack handshake; busy = cycles local_busy stays high after accept
  task automatic tx_send(input bit tgt, input logic [15:0] target, input br_payload_t pl, input int busy);
    br_data_t exp;
    int n;
    exp.source = 16'h0101;
    exp.target = tgt ? target : 16'h0000;
    exp.service = tgt ? BR_SVC_TGT : BR_SVC_ALL;
    exp.id = br_id_t'(sent % (1 << BR_ID_W));
    exp.payload = pl;
    local_busy = busy > 0;
    tx_valid = 1; tx_tgt = tgt; tx_target = target; tx_payload = pl;
    n = 0;
    while (!tx_ready && n < 10) begin step(); n++; end
    n_cmp++; if (tx_ready !== 1'b1) begin n_err++; $display("FAIL tx_ready_wait got %b want 1", tx_ready); end
    step();
    sent++;
    tx_valid = 0; tx_tgt = 1'($urandom); tx_target = 16'($urandom); tx_payload = br_payload_t'($urandom);
    for (int i = 0; i < busy; i++) begin
      n_cmp++; if (br_req_o !== 1'b0) begin n_err++; $display("FAIL tx_busy_hold cyc %0d got %b want 0", i, br_req_o); end
      step();
    end
    local_busy = 0;
    n_cmp++; if (br_req_o !== 1'b0 || tx_ready !== 1'b0) begin n_err++; $display("FAIL tx_wait got req=%b rdy=%b want 0 0", br_req_o, tx_ready); end
    step();
    n_cmp++; if (br_req_o !== 1'b1) begin n_err++; $display("FAIL tx_req_rise got %b want 1", br_req_o); end
    n_cmp++; if (br_flit_o !== exp) begin n_err++; $display("FAIL tx_flit got %h want %h", br_flit_o, exp); end
    n = $urandom_range(0, 3);
    for (int i = 0; i < n; i++) begin
      step();
      n_cmp++; if (br_req_o !== 1'b1 || br_flit_o !== exp) begin n_err++; $display("FAIL tx_req_hold got req=%b flit=%h want 1 %h", br_req_o, br_flit_o, exp); end
    end
    br_ack_i = 1;
    step();
    n_cmp++; if (br_req_o !== 1'b0 || tx_ready !== 1'b0) begin n_err++; $display("FAIL tx_release got req=%b rdy=%b want 0 0", br_req_o, tx_ready); end
    n = $urandom_range(0, 2);
    for (int i = 0; i < n; i++) begin
      step();
      n_cmp++; if (tx_ready !== 1'b0 || br_flit_o !== exp) begin n_err++; $display("FAIL tx_ack_hold got rdy=%b flit=%h want 0 %h", tx_ready, br_flit_o, exp); end
    end
    br_ack_i = 0;
    step();
    n_cmp++; if (tx_ready !== 1'b1) begin n_err++; $display("FAIL tx_ready_return got %b want 1", tx_ready); end
  endtask

  task automatic test_tx_basic();
    tx_send(1'b1, 16'h0202, 8'hAB, 0);
  endtask

  task automatic test_tx_busy();
    tx_send(1'b0, 16'h7777, 8'h5C, 20);
  endtask

  task automatic test_tx_ids();
    for (int i = 0; i < 3; i++) tx_send(1'b1, 16'h0300 + 16'(i), br_payload_t'(i), 0);
    for (int i = 0; i < 16; i++) tx_send(1'($urandom), 16'($urandom), br_payload_t'($urandom), $urandom_range(0, 3));
  endtask

  // router side: offer one flit; ack is expected iff the model has room or the flit is a dropped CLEAR
  task automatic rx_deliver(input br_data_t f);
    bit drop, take;
    drop = f.service == BR_SVC_CLEAR && !FWD;
    take = drop || rxq.size() < DEPTH;
    br_req_i = 1; br_flit_i = f;
    step();
    if (take && !drop) rxq.push_back(f);
    n_cmp++; if (br_ack_o !== take) begin n_err++; $display("FAIL rx_ack got %b want %b", br_ack_o, take); end
    step();
    n_cmp++; if (br_ack_o !== take || rx_count !== 3'(rxq.size())) begin n_err++; $display("FAIL rx_ack_hold got ack=%b cnt=%0d want %b %0d", br_ack_o, rx_count, take, rxq.size()); end
    br_req_i = 0; br_flit_i = rand_flit();
    step();
    n_cmp++; if (br_ack_o !== 1'b0) begin n_err++; $display("FAIL rx_ack_drop got %b want 0", br_ack_o); end
  endtask

  task automatic rx_pop();
    rx_ready = 1;
    n_cmp++; if (rx_valid !== 1'b1 || rx_data !== rxq[0]) begin n_err++; $display("FAIL rx_head got v=%b d=%h want 1 %h", rx_valid, rx_data, rxq[0]); end
    step();
    rx_ready = 0;
    void'(rxq.pop_front());
    n_cmp++; if (rx_count !== 3'(rxq.size())) begin n_err++; $display("FAIL rx_count_pop got %0d want %0d", rx_count, rxq.size()); end
  endtask

  task automatic test_rx_full();
    br_data_t f;
    for (int i = 0; i < DEPTH; i++) begin
      f = rand_flit(); f.service = BR_SVC_ALL;
      rx_deliver(f);
    end
    f = rand_flit(); f.service = BR_SVC_ALL;
    br_req_i = 1; br_flit_i = f;
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++; if (br_ack_o !== 1'b0 || rx_count !== 3'd4) begin n_err++; $display("FAIL rx_full_stall got ack=%b cnt=%0d want 0 4", br_ack_o, rx_count); end
    end
    rx_ready = 1;
    n_cmp++; if (rx_data !== rxq[0]) begin n_err++; $display("FAIL rx_full_head got %h want %h", rx_data, rxq[0]); end
    step();
    rx_ready = 0;
    void'(rxq.pop_front());
    n_cmp++; if (br_ack_o !== 1'b0 || rx_count !== 3'd3) begin n_err++; $display("FAIL rx_pop_noack got ack=%b cnt=%0d want 0 3", br_ack_o, rx_count); end
    step();
    rxq.push_back(f);
    n_cmp++; if (br_ack_o !== 1'b1 || rx_count !== 3'd4) begin n_err++; $display("FAIL rx_fifth_ack got ack=%b cnt=%0d want 1 4", br_ack_o, rx_count); end
    br_req_i = 0;
    step();
    n_cmp++; if (br_ack_o !== 1'b0) begin n_err++; $display("FAIL rx_fifth_drop got %b want 0", br_ack_o); end
    while (rxq.size() > 0) rx_pop();
    n_cmp++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL rx_empty got %b want 0", rx_valid); end
  endtask

  task automatic test_clear();
    br_data_t f;
    f = rand_flit(); f.service = BR_SVC_CLEAR;
    rx_deliver(f);
    for (int i = 0; rxq.size() < DEPTH && i < 8; i++) begin
      f = rand_flit(); f.service = BR_SVC_TGT;
      rx_deliver(f);
    end
    f = rand_flit(); f.service = BR_SVC_CLEAR;
    rx_deliver(f);
    while (rxq.size() > 0) rx_pop();
  endtask

  task automatic test_rx_random();
    for (int i = 0; i < 40; i++) begin
      if (rxq.size() > 0 && $urandom_range(0, 2) == 0) rx_pop();
      else rx_deliver(rand_flit());
    end
    while (rxq.size() > 0) rx_pop();
  endtask

  task automatic test_reset_mid();
    tx_valid = 1; tx_tgt = 1; tx_target = 16'h0404; tx_payload = 8'h11; local_busy = 0;
    step();
    tx_valid = 0;
    step();
    br_req_i = 1; br_flit_i = rand_flit(); br_flit_i.service = BR_SVC_ALL;
    step();
    n_cmp++; if (br_req_o !== 1'b1 || br_ack_o !== 1'b1) begin n_err++; $display("FAIL mid_setup got req=%b ack=%b want 1 1", br_req_o, br_ack_o); end
    #2 rst = 1;
    #1;
    n_cmp++; if ({br_req_o, br_ack_o, rx_valid, tx_ready} !== 4'b0 || rx_count !== 3'd0) begin n_err++; $display("FAIL mid_reset got %b cnt=%0d want 0000 0", {br_req_o, br_ack_o, rx_valid, tx_ready}, rx_count); end
    br_req_i = 0;
    step();
    rst = 0;
    sent = 0;
    rxq.delete();
    n_cmp++; if (tx_ready !== 1'b0) begin n_err++; $display("FAIL mid_release_early got %b want 0", tx_ready); end
    step();
    n_cmp++; if (tx_ready !== 1'b1) begin n_err++; $display("FAIL mid_release_ready got %b want 1", tx_ready); end
    tx_send(1'b0, 16'h0000, 8'h99, 1);
  endtask

  initial begin
    test_reset();
    test_tx_basic();
    test_tx_busy();
    test_tx_ids();
    test_rx_full();
    test_clear();
    test_rx_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule

// File: doc/br_lite_local_ni.md
Name: br_lite_local_ni

Overview:
PE-side network interface on the BrLite router LOCAL port; it is the other end of the router's local req/ack protocol.
- TX path: accepts broadcast requests from the PE over valid/ready, stamps `source` and `id`, injects them into the router, and respects `local_busy`.
- RX path: accepts flits the router delivers on LOCAL, queues them in a FIFO, and hands them to the PE over valid/ready.
- Both paths are fully independent.

Parameters:
- ADDRESS, 16'h0000, this PE's address; stamped into `source`.
- RX_DEPTH, 4, RX FIFO entries; power of two, ≥2.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- tx_valid_i  in  1  PE request valid
- tx_ready_o  out  1  NI can accept a request
- tx_tgt_i  in  1  1 = BR_SVC_TGT, 0 = BR_SVC_ALL
- tx_target_i  in  16  target address (used only when tgt)
- tx_payload_i  in  br_payload_t  payload
- br_flit_o  out  br_data_t  flit to router LOCAL input
- br_req_o  out  1  req to router
- br_ack_i  in  1  ack from router
- local_busy_i  in  1  router local_busy_o
- br_flit_i  in  br_data_t  flit from router LOCAL output
- br_req_i  in  1  req from router
- br_ack_o  out  1  ack to router
- rx_valid_o  out  1  FIFO head valid
- rx_ready_i  in  1  PE pops head
- rx_data_o  out  br_data_t  FIFO head
- rx_count_o  out  $clog2(RX_DEPTH)+1  FIFO occupancy

Behaviour:
- Clock and reset are decided: one clock; reset asynchronous and active-high.
- Reset values: all outputs 0; TX FSM TX_IDLE; FIFO empty; id counter 0.
- Reset mid-transaction: req/ack drop immediately; no partial recovery.

TX FSM:
- States: TX_IDLE, TX_WAIT, TX_REQ, TX_RELEASE.
- tx_ready_o = (state == TX_IDLE).
- TX_IDLE:
  - On tx_valid_i && tx_ready_o, latch flit into the holding register: source = ADDRESS, id = id_cnt, service = TGT/ALL, target = tx_target_i (0 when ALL), payload.
  - id_cnt++ (wraps modulo id field width).
  - Next state TX_WAIT.
- TX_WAIT: while local_busy_i, stay; else go to TX_REQ.
- TX_REQ:
  - br_req_o = 1; br_flit_o holds the register, stable from TX_WAIT until TX_RELEASE exits.
  - On br_ack_i, go to TX_RELEASE.
- TX_RELEASE: br_req_o = 0; wait for !br_ack_i, then go to TX_IDLE.
- Minimum TX_IDLE-to-TX_IDLE turnaround: 4 cycles.

RX:
- br_ack_o is registered.
- Cycle where br_req_i && !br_ack_o && !full:
  - push br_flit_i;
  - br_ack_o <= 1.
- br_ack_o stays 1 while br_req_i; it clears the cycle after br_req_i falls. This serves both the router's 4-phase OUT_LOCAL and its level-sampled OUT_ACK_ALL.
- FIFO full: no ack; the router stalls holding req and flit.
- Full is evaluated on registered occupancy: a same-cycle pop does not enable a push.
- CLEAR flits (service == BR_SVC_CLEAR) are acked but not pushed (see optional feature).
- FIFO:
  - first-word-fall-through; rx_valid_o = count != 0; pop on rx_valid_o && rx_ready_i;
  - simultaneous push and pop keep count unchanged;
  - pointers wrap modulo RX_DEPTH.

Optional Feature:
BR_LITE_NI_CLEAR_FWD_EN
- Defined: CLEAR flits are pushed into the RX FIFO like any other flit, with the same full/ack rules.
- Undefined: CLEAR flits are acked and discarded, and never consume FIFO space; with a full FIFO they are still acked.

Decomposition:
- BrLitePkg gains `br_payload_t`, `br_id_t`, and a `br_ni_tx_state_t` enum.
- `br_data_t` and `BR_SVC_*` are reused from BrLitePkg.
- One sub-module: `br_lite_ni_fifo`, parameterised on depth and element type `br_data_t`; carries the push/pop/count logic.

Test Plan:
1. ADDRESS=16'h0101, PE sends tgt=1, target=16'h0202, payload=0xAB → br_flit_o {source 0101, target 0202, TGT, id 0}; br_req_o rises 2 cycles after accept; falls the cycle after br_ack_i; tx_ready_o returns once ack drops.
2. local_busy_i held high 20 cycles during TX_WAIT → br_req_o stays 0 for those 20 cycles; asserts the cycle after busy falls.
3. 3 consecutive sends → ids 0, 1, 2. Preload id_cnt at max → next id 0 (wrap).
4. Router delivers 5 ALL flits with rx_ready_i = 0, RX_DEPTH = 4 → 4 acked (each ack held until req drop); 5th req unacked; rx_count_o = 4. One pop → 5th acked next cycle; order preserved.
5. Router delivers CLEAR flit:
   - without macro → acked, rx_count_o unchanged;
   - with BR_LITE_NI_CLEAR_FWD_EN → pushed, rx_count_o +1.
6. Assert rst_i during TX_REQ and during RX ack hold → br_req_o, br_ack_o, rx_valid_o, tx_ready_o = 0 immediately; tx_ready_o = 1 the first clock after release.
